pll_nco_multi: RTL and testbench
================================

PLL_NCO_MULTI -- requirements
Module: pll_nco_multi

Interface
REQ-001 The block SHALL have parameter NCH, default 4: number of output clock channels, range 1..16.
REQ-002 The block SHALL have parameter ACC_W, default 32: phase accumulator and frequency word width, range 8..48.
REQ-003 The block SHALL have parameter CH_W, default 2: channel select width, with 2^CH_W >= NCH.
REQ-004 The block SHALL have parameter LOCK_CNT, default 16: settle cycles before locked asserts, range 1..65535.
REQ-005 The block SHALL have port refclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: configuration request.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: configuration can be accepted.
REQ-009 The block SHALL have port cfg_ch, input, CH_W bits: target channel.
REQ-010 The block SHALL have port cfg_freq, input, ACC_W bits: frequency word; fout = f_refclk * cfg_freq / 2^ACC_W.
REQ-011 The block SHALL have port cfg_phase, input, ACC_W bits: accumulator preload (phase offset).
REQ-012 The block SHALL have port outclk, output, NCH bits: per-channel clock, equal to the accumulator MSB.
REQ-013 The block SHALL have port tick, output, NCH bits: one-cycle pulse on each accumulator wrap.
REQ-014 The block SHALL have port locked, output, 1 bit: all channels settled after the last reconfiguration.

Function
REQ-015 Each channel SHALL hold a registered accumulator acc[i] and frequency word freq[i], both ACC_W bits.
REQ-016 Each cycle, acc[i] SHALL update to (acc[i] + freq[i]) mod 2^ACC_W.
REQ-017 tick[i] SHALL be registered and high exactly in the cycle after an addition carried out of bit ACC_W-1.
REQ-018 outclk[i] SHALL equal acc[i][ACC_W-1] with no combinational path from any input.
REQ-019 freq[i]=0 SHALL freeze acc[i]: outclk[i] holds its value and tick[i] stays 0.
REQ-020 A request SHALL be accepted on a rising edge with cfg_valid=1 and cfg_ready=1; the cfg_* inputs are sampled on that edge.
REQ-021 The FSM SHALL have states SETTLE, LOCKED and APPLY.
REQ-022 On acceptance in SETTLE or LOCKED, the FSM SHALL enter APPLY for exactly one cycle.
REQ-023 On the acceptance edge, locked SHALL clear and the settle counter SHALL load LOCK_CNT.
REQ-024 On the APPLY-exit edge, freq[cfg_ch] SHALL load cfg_freq and acc[cfg_ch] SHALL load cfg_phase, with no addition and tick[cfg_ch]=0 for that cycle.
REQ-025 On the APPLY-exit edge, the FSM SHALL go to SETTLE.
REQ-026 In APPLY, cfg_ready SHALL be 0; in every other state after reset it SHALL be 1.
REQ-027 In SETTLE, the counter SHALL decrement each cycle; on the edge where it reaches 0, the FSM SHALL go to LOCKED and locked SHALL go to 1.
REQ-028 An acceptance during SETTLE SHALL restart the settle count from LOCK_CNT.
REQ-029 An acceptance with cfg_ch >= NCH SHALL follow the APPLY/SETTLE sequence with no channel register changed.
REQ-030 Channels not addressed by an APPLY SHALL keep running uninterrupted.

Reset
REQ-031 While rst=0 at an edge, the block SHALL set all acc=0, freq=0, outclk=0, tick=0, locked=0, cfg_ready=0, state SETTLE and counter LOCK_CNT.
REQ-032 On the first edge with rst=1, cfg_ready SHALL become 1 and the settle count SHALL begin.
REQ-033 locked SHALL assert on the LOCK_CNT-th edge with rst=1 when no request is accepted.
REQ-034 rst=0 at any point, including APPLY, SHALL abort the pending update and return the block to the reset state.

Verification (NCH=4, ACC_W=8, LOCK_CNT=4)
REQ-035 The bench SHALL cover release rst -> locked=0 for 3 edges, locked=1 on the 4th; outclk=0 and tick=0 throughout.
REQ-036 The bench SHALL cover cfg ch0 freq=0x40 phase=0x00 -> cfg_ready low 1 cycle; then tick[0] every 4 cycles, outclk[0] 2 high/2 low; locked after 4 cycles.
REQ-037 The bench SHALL cover ch1 freq=0x40 phase=0x80 after ch0 runs -> outclk[1]=~outclk[0] every cycle; ch0 uninterrupted.
REQ-038 The bench SHALL cover ch2 freq=0x03 -> tick[2] intervals of 85 or 86 cycles; mean period 256/3 over 768 cycles (9 ticks).
REQ-039 The bench SHALL cover a second request 2 cycles into SETTLE -> locked delayed to 4 cycles after the second APPLY; cfg_ch=3 with freq=0 stops only ch3.
REQ-040 The bench SHALL cover rst=0 during APPLY -> next cycle all outputs 0, freq unchanged at 0, cfg_ready=0.

Source files
------------

// File: rtl/pll_nco_multi.sv
// Multi-channel phase-accumulator NCO. Channels are reconfigured one at a time
// through a valid/ready port; locked reports that every channel has settled.
module pll_nco_multi #(
  parameter int NCH      = 4,
  parameter int ACC_W    = 32,
  parameter int CH_W     = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [ACC_W-1:0] cfg_freq,
  input  logic [ACC_W-1:0] cfg_phase,
  output logic [NCH-1:0]   outclk,
  output logic [NCH-1:0]   tick,
  output logic             locked
);

  localparam int              CNT_W    = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    APPLY  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_locked;
  logic             w_locked_nxt;
  logic             r_ready;
  logic             w_accept;
  logic [CH_W-1:0]  r_cfg_ch;
  logic [ACC_W-1:0] r_cfg_freq;
  logic [ACC_W-1:0] r_cfg_phase;

  assign w_accept  = cfg_valid & r_ready;
  assign cfg_ready = r_ready;
  assign locked    = r_locked;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_locked_nxt = r_locked;
    case (r_state)
      SETTLE: begin
        if (w_accept) begin
          w_state_nxt  = APPLY;
          w_cnt_nxt    = CNT_LOAD;
          w_locked_nxt = 1'b0;
        end else if (r_cnt <= CNT_ONE) begin
          w_state_nxt  = LOCKED;
          w_cnt_nxt    = '0;
          w_locked_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end
      LOCKED: begin
        if (w_accept) begin
          w_state_nxt  = APPLY;
          w_cnt_nxt    = CNT_LOAD;
          w_locked_nxt = 1'b0;
        end
      end
      APPLY:   w_state_nxt = SETTLE;
      default: w_state_nxt = SETTLE;
    endcase
  end

  // cfg_ready is registered from the next state so it drops for exactly the APPLY cycle
  always_ff @(posedge refclk) begin
    if (!rst) begin
      r_state  <= SETTLE;
      r_cnt    <= CNT_LOAD;
      r_locked <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_locked <= w_locked_nxt;
      r_ready  <= (w_state_nxt != APPLY);
    end
  end

  always_ff @(posedge refclk) begin
    if (w_accept) begin
      r_cfg_ch    <= cfg_ch;
      r_cfg_freq  <= cfg_freq;
      r_cfg_phase <= cfg_phase;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_freq;
    logic             r_tick;
    logic [ACC_W:0]   w_sum;
    logic             w_load;

    assign w_sum  = {1'b0, r_acc} + {1'b0, r_freq};
    assign w_load = (r_state == APPLY) && (r_cfg_ch == CH_W'(gi));

    // The carry out of the accumulator is the wrap indication
    always_ff @(posedge refclk) begin
      if (!rst) begin
        r_acc  <= '0;
        r_freq <= '0;
        r_tick <= 1'b0;
      end else if (w_load) begin
        r_acc  <= r_cfg_phase;
        r_freq <= r_cfg_freq;
        r_tick <= 1'b0;
      end else begin
        r_acc  <= w_sum[ACC_W-1:0];
        r_tick <= w_sum[ACC_W];
      end
    end

    assign outclk[gi] = r_acc[ACC_W-1];
    assign tick[gi]   = r_tick;
  end

endmodule

// File: tb/tb_pll_nco_multi.sv
// Directed bench for pll_nco_multi (NCH=4, ACC_W=8, LOCK_CNT=4): a vector table
// for reset release and the first channel, then hand-written multi-cycle sequences.
module tb_pll_nco_multi;

  localparam int NCH      = 4;
  localparam int ACC_W    = 8;
  localparam int CH_W     = 2;
  localparam int LOCK_CNT = 4;

  logic             refclk = 1'b0;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_freq;
  logic [ACC_W-1:0] cfg_phase;
  logic [NCH-1:0]   outclk;
  logic [NCH-1:0]   tick;
  logic             locked;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic       v;
    logic [1:0] ch;
    logic [7:0] f;
    logic [7:0] p;
    logic       e_rdy;
    logic       e_lck;
    logic [3:0] e_out;
    logic [3:0] e_tick;
  } vec_t;

  vec_t tbl [14];

  always #5 refclk = ~refclk;

  pll_nco_multi #(
    .NCH(NCH), .ACC_W(ACC_W), .CH_W(CH_W), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_freq(cfg_freq), .cfg_phase(cfg_phase),
    .outclk(outclk), .tick(tick), .locked(locked)
  );

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] f,
                       input logic [7:0] p);
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_freq  = f;
    cfg_phase = p;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  last_t;
    int  n_t0;
    int  n_t1;
    int  n_t2;
    int  bad;
    logic e;

    //            v     ch     f      p      rdy   lck   out    tick
    tbl[0]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[2]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h0, 4'h0};
    tbl[4]  = '{1'b1, 2'd0, 8'h40, 8'h00, 1'b0, 1'b0, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[6]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0};
    tbl[7]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 4'h1, 4'h0};
    tbl[8]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 4'h1, 4'h0};
    tbl[9]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h0, 4'h1};
    tbl[10] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h0, 4'h0};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h1, 4'h0};
    tbl[12] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h1, 4'h0};
    tbl[13] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 4'h0, 4'h1};

    // Reset state
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    repeat (3) step();
    chk("rst_ready",  32'(cfg_ready), 32'd0);
    chk("rst_locked", 32'(locked),    32'd0);
    chk("rst_outclk", 32'(outclk),    32'd0);
    chk("rst_tick",   32'(tick),      32'd0);

    // Reset release, lock, and channel 0 configuration
    rst = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].ch, tbl[i].f, tbl[i].p);
      step();
      chk($sformatf("vec%0d", i),
          {22'd0, cfg_ready, locked, outclk, tick},
          {22'd0, tbl[i].e_rdy, tbl[i].e_lck, tbl[i].e_out, tbl[i].e_tick});
    end

    // Channel 1 in antiphase; channel 0 keeps running through the update
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    step();
    step();
    drive(1'b1, 2'd1, 8'h40, 8'h80);
    step();
    chk("A_acc_state", {28'd0, cfg_ready, locked, outclk[0], tick[0]}, {28'd0, 4'b0010});
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    step();
    chk("A_exit", {22'd0, cfg_ready, locked, outclk, tick}, {22'd0, 1'b1, 1'b0, 4'b0010, 4'b0001});
    for (int k = 1; k <= 12; k++) begin
      step();
      e = ((k % 4) == 2) || ((k % 4) == 3);
      chk($sformatf("A_out_k%0d", k), 32'(outclk), 32'({2'b00, ~e, e}));
      chk($sformatf("A_tick_k%0d", k), 32'(tick), 32'({2'b00, (k % 4) == 2, (k % 4) == 0}));
      if (k <= 5) chk($sformatf("A_lock_k%0d", k), 32'(locked), 32'(k >= 4));
    end

    // Channel 2 at freq 3: ticks 85/86 cycles apart, 9 in 768 cycles
    drive(1'b1, 2'd2, 8'h03, 8'h00);
    step();
    chk("B_ready", 32'(cfg_ready), 32'd0);
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    step();
    last_t = 0;
    n_t0 = 0;
    n_t1 = 0;
    n_t2 = 0;
    for (int c = 1; c <= 768; c++) begin
      step();
      if (tick[2]) begin
        if (n_t2 == 0) chk("B_first", 32'(c), 32'd86);
        else chk($sformatf("B_intv_%0d", c), 32'(((c - last_t) == 85) || ((c - last_t) == 86)), 32'd1);
        n_t2++;
        last_t = c;
      end
      n_t0 += int'(tick[0]);
      n_t1 += int'(tick[1]);
    end
    chk("B_count", 32'(n_t2), 32'd9);
    chk("B_last",  32'(last_t), 32'd768);
    chk("B_t0",    32'(n_t0), 32'd192);
    chk("B_t1",    32'(n_t1), 32'd192);
    chk("B_lock",  32'(locked), 32'd1);

    // Second request 2 cycles into SETTLE restarts the count; freq 0 freezes ch3 only
    drive(1'b1, 2'd3, 8'h10, 8'h00);
    step();
    chk("D_lock_clr", 32'(locked), 32'd0);
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    step();
    step();
    step();
    chk("D_lock_mid", 32'(locked), 32'd0);
    drive(1'b1, 2'd3, 8'h00, 8'h90);
    step();
    chk("D_ready", 32'(cfg_ready), 32'd0);
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    step();
    chk("D_load", {30'd0, outclk[3], tick[3]}, {30'd0, 2'b10});
    bad = 0;
    n_t0 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k <= 5) chk($sformatf("D_lock_k%0d", k), 32'(locked), 32'(k >= 4));
      if (outclk[3] !== 1'b1 || tick[3] !== 1'b0 || outclk[1] !== ~outclk[0]) bad++;
      n_t0 += int'(tick[0]);
    end
    chk("D_freeze", 32'(bad), 32'd0);
    chk("D_ch0_run", 32'(n_t0), 32'd5);

    // Reset during APPLY aborts the pending update
    drive(1'b1, 2'd3, 8'h20, 8'h00);
    step();
    chk("C_ready", 32'(cfg_ready), 32'd0);
    rst = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 8'h00);
    step();
    chk("C_rst", {22'd0, cfg_ready, locked, outclk, tick}, 32'd0);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("C_idle_k%0d", k), {24'd0, outclk, tick}, 32'd0);
      chk($sformatf("C_lock_k%0d", k), {30'd0, cfg_ready, locked}, {30'd0, 1'b1, k >= 4});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
